// File: rtl/excp_commit.sv
// +------------------------------------------------------------------------+
// | Module   : excp_commit                                                 |
// | Purpose  : Commit-stage exception/ERTN handler driving CSR strobes,    |
// |            pipeline flush and a fetch redirect handshake.              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module excp_commit #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_excp,
  input  logic        wb_ertn,
  output logic        wb_ready,
  output logic        commit_valid,
  input  logic        has_int,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [31:0] era_in,
  output logic [5:0]  ecode_in,
  output logic [8:0]  esubcode_in,
  output logic        flush_pipe,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  localparam logic [3:0] c_drain_load = 4'(DRAIN_CYCLES - 1);

  localparam logic [5:0] c_ecode_int  = 6'h00;
  localparam logic [5:0] c_ecode_adef = 6'h08;
  localparam logic [5:0] c_ecode_ine  = 6'h0D;
  localparam logic [5:0] c_ecode_sys  = 6'h0B;
  localparam logic [5:0] c_ecode_brk  = 6'h0C;
  localparam logic [5:0] c_ecode_ale  = 6'h09;
  localparam logic [5:0] c_ecode_none = 6'h00;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_era;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic        r_is_ertn;
  logic [31:0] r_redirect_pc;
  logic [3:0]  r_cnt;

  logic        w_idle;
  logic        w_event;
  logic        w_accept;
  logic [5:0]  w_ecode;
  logic        w_is_ertn;
  logic        w_unused_eentry;

  // The entry vector is 64-byte aligned; its low bits never reach fetch.
  assign w_unused_eentry = ^eentry[5:0];

  assign w_idle   = (r_state == S_IDLE);
  assign w_event  = wb_valid & (has_int | (|wb_excp) | wb_ertn);
  assign w_accept = w_idle & ~reset & w_event;

  // Interrupt outranks every exception; any exception suppresses ERTN.
  always_comb begin
    w_ecode   = c_ecode_none;
    w_is_ertn = 1'b0;
    if (has_int)         w_ecode = c_ecode_int;
    else if (wb_excp[4]) w_ecode = c_ecode_adef;
    else if (wb_excp[3]) w_ecode = c_ecode_ine;
    else if (wb_excp[2]) w_ecode = c_ecode_sys;
    else if (wb_excp[1]) w_ecode = c_ecode_brk;
    else if (wb_excp[0]) w_ecode = c_ecode_ale;
    else                 w_is_ertn = wb_ertn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_era         <= '0;
      r_ecode       <= '0;
      r_esubcode    <= '0;
      r_is_ertn     <= 1'b0;
      r_redirect_pc <= '0;
      r_cnt         <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_era      <= wb_pc;
        r_ecode    <= w_ecode;
        r_esubcode <= 9'd0;
        r_is_ertn  <= w_is_ertn;
      end
      if (r_state == S_FLUSH)
        r_redirect_pc <= r_is_ertn ? era : {eentry[31:6], 6'b0};
      if ((r_state == S_REDIRECT) && redirect_ready)
        r_cnt <= c_drain_load;
      else if ((r_state == S_DRAIN) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    wb_ready       = 1'b0;
    commit_valid   = 1'b0;
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    flush_pipe     = 1'b0;
    redirect_valid = 1'b0;
    era_in         = '0;
    ecode_in       = '0;
    esubcode_in    = '0;
    redirect_pc    = '0;

    case (r_state)
      S_IDLE:     if (w_event) w_state_nxt = S_FLUSH;
      S_FLUSH:    w_state_nxt = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) w_state_nxt = S_DRAIN;
      S_DRAIN:    if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase

    // Every output is forced quiet while reset is held, not just after it.
    if (!reset) begin
      wb_ready       = w_idle;
      commit_valid   = wb_valid & w_idle & ~has_int & ~(|wb_excp) & ~wb_ertn;
      excp_flush     = (r_state == S_FLUSH) & ~r_is_ertn;
      ertn_flush     = (r_state == S_FLUSH) &  r_is_ertn;
      flush_pipe     = ~w_idle;
      redirect_valid = (r_state == S_REDIRECT);
      era_in         = r_era;
      ecode_in       = r_ecode;
      esubcode_in    = r_esubcode;
      redirect_pc    = r_redirect_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_excp_commit.sv
// +------------------------------------------------------------------------+
// | Module   : tb_excp_commit                                              |
// | Purpose  : Self-checking bench for excp_commit against a priority and  |
// |            timeline reference model with randomized events.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_excp_commit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_excp;
  logic        wb_ertn;
  logic        wb_ready;
  logic        commit_valid;
  logic        has_int;
  logic [31:0] eentry;
  logic [31:0] era;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] era_in;
  logic [5:0]  ecode_in;
  logic [8:0]  esubcode_in;
  logic        flush_pipe;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  excp_commit #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_ertn(wb_ertn),
    .wb_ready(wb_ready), .commit_valid(commit_valid),
    .has_int(has_int), .eentry(eentry), .era(era),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .era_in(era_in), .ecode_in(ecode_in), .esubcode_in(esubcode_in),
    .flush_pipe(flush_pipe),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interrupt first, then exception flags from adef down to ale,
  // and ERTN only when nothing else is pending.
  function automatic void ref_event(input bit intr, input logic [4:0] ex, input bit er,
                                    output bit is_ertn, output logic [5:0] code);
    logic [5:0] tbl [5] = '{6'h09, 6'h0C, 6'h0B, 6'h0D, 6'h08};
    is_ertn = 1'b0;
    code    = 6'h00;
    if (!intr) begin
      if (ex == 5'd0) is_ertn = er;
      else begin
        for (int b = 0; b < 5; b++)
          if (ex[b]) code = tbl[b];
      end
    end
  endfunction

  task automatic drive_junk();
    wb_valid = 1'b1;
    wb_pc    = $urandom;
    wb_excp  = 5'($urandom);
    wb_ertn  = 1'($urandom);
    has_int  = 1'($urandom);
  endtask

  task automatic drive_idle();
    wb_valid = 1'b0;
    wb_excp  = '0;
    wb_ertn  = 1'b0;
    has_int  = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".wb_ready"}, wb_ready, 0);
    chk({nm, ".commit_valid"}, commit_valid, 0);
    chk({nm, ".excp_flush"}, excp_flush, 0);
    chk({nm, ".ertn_flush"}, ertn_flush, 0);
    chk({nm, ".flush_pipe"}, flush_pipe, 0);
    chk({nm, ".redirect_valid"}, redirect_valid, 0);
    chk({nm, ".era_in"}, era_in, 0);
    chk({nm, ".ecode_in"}, ecode_in, 0);
    chk({nm, ".esubcode_in"}, esubcode_in, 0);
    chk({nm, ".redirect_pc"}, redirect_pc, 0);
  endtask

  // One full event: accept, FLUSH, REDIRECT for delay+1 cycles, D drain cycles, back to idle.
  task automatic do_event(input string nm, input logic [31:0] pc, input logic [4:0] ex,
                          input bit er, input bit intr, input logic [31:0] ee,
                          input logic [31:0] ra, input int delay);
    bit         is_e;
    logic [5:0] code;
    logic [31:0] tgt;
    ref_event(intr, ex, er, is_e, code);
    tgt = is_e ? ra : {ee[31:6], 6'b0};

    wb_valid = 1'b1; wb_pc = pc; wb_excp = ex; wb_ertn = er; has_int = intr;
    eentry = ee; era = ra; redirect_ready = 1'($urandom);
    #1;
    chk({nm, ".accept.wb_ready"}, wb_ready, 1);
    chk({nm, ".accept.commit_valid"}, commit_valid, 0);
    chk({nm, ".accept.flush_pipe"}, flush_pipe, 0);
    tick();

    drive_junk();
    #1;
    chk({nm, ".flush.excp_flush"}, excp_flush, !is_e);
    chk({nm, ".flush.ertn_flush"}, ertn_flush, is_e);
    chk({nm, ".flush.era_in"}, era_in, pc);
    chk({nm, ".flush.ecode_in"}, ecode_in, code);
    chk({nm, ".flush.esubcode_in"}, esubcode_in, 0);
    chk({nm, ".flush.flush_pipe"}, flush_pipe, 1);
    chk({nm, ".flush.wb_ready"}, wb_ready, 0);
    chk({nm, ".flush.commit_valid"}, commit_valid, 0);
    chk({nm, ".flush.redirect_valid"}, redirect_valid, 0);
    tick();

    for (int k = 0; k <= delay; k++) begin
      drive_junk();
      eentry = $urandom; era = $urandom;
      redirect_ready = (k == delay);
      #1;
      chk({nm, ".redir.redirect_valid"}, redirect_valid, 1);
      chk({nm, ".redir.redirect_pc"}, redirect_pc, tgt);
      chk({nm, ".redir.excp_flush"}, excp_flush, 0);
      chk({nm, ".redir.ertn_flush"}, ertn_flush, 0);
      chk({nm, ".redir.wb_ready"}, wb_ready, 0);
      chk({nm, ".redir.flush_pipe"}, flush_pipe, 1);
      tick();
    end

    for (int k = 0; k < D; k++) begin
      drive_junk();
      redirect_ready = 1'($urandom);
      #1;
      chk({nm, ".drain.wb_ready"}, wb_ready, 0);
      chk({nm, ".drain.flush_pipe"}, flush_pipe, 1);
      chk({nm, ".drain.redirect_valid"}, redirect_valid, 0);
      chk({nm, ".drain.strobes"}, {excp_flush, ertn_flush}, 0);
      tick();
    end

    drive_idle();
    #1;
    chk({nm, ".idle.wb_ready"}, wb_ready, 1);
    chk({nm, ".idle.flush_pipe"}, flush_pipe, 0);
    chk({nm, ".idle.era_in_held"}, era_in, pc);
    chk({nm, ".idle.ecode_held"}, ecode_in, code);
    chk({nm, ".idle.strobes"}, {excp_flush, ertn_flush}, 0);
    tick();
  endtask

  task automatic do_commits(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      wb_valid = 1'b1; wb_pc = $urandom; wb_excp = '0; wb_ertn = 1'b0; has_int = 1'b0;
      #1;
      chk({nm, ".commit_valid"}, commit_valid, 1);
      chk({nm, ".wb_ready"}, wb_ready, 1);
      chk({nm, ".flush_pipe"}, flush_pipe, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; redirect_ready = 1'b0;
    wb_valid = 1'b1; wb_pc = 32'h1234; wb_excp = 5'b00001; wb_ertn = 1'b1; has_int = 1'b1;
    eentry = 32'h1C008000; era = 32'h0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    drive_idle();
    #1;
    chk("post_reset.wb_ready", wb_ready, 1);
    tick();

    do_event("sys", 32'h1C000100, 5'b00100, 1'b0, 1'b0, 32'h1C008044, 32'hDEAD0000, 0);
    do_event("ertn", 32'h1C000300, 5'b00000, 1'b1, 1'b0, 32'h1C008044, 32'h1C000204, 3);
    do_event("int_all", 32'h1C000400, 5'b11111, 1'b1, 1'b1, 32'h1C0080FF, 32'h1C000204, 1);
    do_event("ale_ertn", 32'h1C000500, 5'b00001, 1'b1, 1'b0, 32'h2000007F, 32'h1C000604, 0);

    do_commits("commit5", 5);

    // An interrupt with no presented instruction is not taken.
    wb_valid = 1'b0; has_int = 1'b1;
    #1;
    chk("int_novalid.commit_valid", commit_valid, 0);
    tick();
    drive_idle();
    #1;
    chk("int_novalid.flush_pipe", flush_pipe, 0);
    chk("int_novalid.excp_flush", excp_flush, 0);
    tick();

    for (int i = 0; i < 24; i++) begin
      logic [4:0] ex;
      bit er, intr;
      ex   = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
      er   = 1'($urandom);
      intr = ($urandom % 4 == 0);
      if (!intr && ex == 5'd0 && !er) do_commits("rnd_commit", 1 + $urandom % 3);
      else do_event("rnd", $urandom, ex, er, intr, $urandom, $urandom, $urandom % 4);
    end

    // Reset landing while the redirect is still waiting for fetch.
    wb_valid = 1'b1; wb_pc = 32'h1C000700; wb_excp = 5'b00010; wb_ertn = 1'b0; has_int = 1'b0;
    eentry = 32'h1C00A000; redirect_ready = 1'b0;
    tick();
    drive_idle();
    tick();
    #1;
    chk("rst_mid.redirect_valid", redirect_valid, 1);
    tick();
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid.during");
    tick();
    check_all_zero("rst_mid.after_edge");
    reset = 1'b0;
    redirect_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rst_mid.wb_ready", wb_ready, 1);
      chk("rst_mid.quiet", {excp_flush, ertn_flush, flush_pipe, redirect_valid}, 0);
      tick();
    end

    do_event("after_rst", 32'h1C000800, 5'b10000, 1'b0, 1'b0, 32'h1C00C0C0, 32'h0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
